instruction_fetch_unit: RTL and testbench

//  Front end of the 32-bit MIPS pipeline: owns the PC register and fetches one instruction per request from instruction memory.

---
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Front end of the 32-bit MIPS pipeline. Owns the PC and fetches
//               one instruction per request, with at most one request in
//               flight. Delivers {instruction, PC+4} to decode over a
//               valid/ready handshake. A redirect from the jump/branch logic
//               reloads the PC and squashes any fetch that is stale.
// Ports       : clk, reset                   - clock, sync active-high reset
//               redirectValid, redirectPC    - next-PC override
//               imemReq/imemAddr/imemReady   - fetch request channel
//               imemRspValid/imemRspData     - fetch response channel
//               outValid/outInstruction/
//               outPC4/outReady              - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirectValid,
    input  logic [31:0] redirectPC,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRspValid,
    input  logic [31:0] imemRspData,
    output logic        outValid,
    output logic [31:0] outInstruction,
    output logic [31:0] outPC4,
    input  logic        outReady
);

    localparam logic [1:0] c_FETCH = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc4_q, out_pc4_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_aligned;

    assign w_pc_plus4         = pc_q + 32'd4;
    assign w_redirect_aligned = redirectPC & ~32'h0000_0003;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_FETCH;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_pc4_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc4_q   <= out_pc4_d;
        end
    end

    // Next-state logic. A redirect always wins over the response, the decode
    // handshake and the sequential PC increment.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc4_d   = out_pc4_q;

        if (redirectValid) begin
            pc_d        = w_redirect_aligned;
            out_valid_d = 1'b0;
        end

        case (state_q)
            c_FETCH: begin
                // The request is accepted even when a redirect arrives in the
                // same cycle; its response must then be discarded.
                if (imemReady) begin
                    state_d = c_WAIT;
                    if (redirectValid) begin
                        kill_d = 1'b1;
                    end
                end
            end
            c_WAIT: begin
                if (redirectValid) begin
                    if (imemRspValid) begin
                        kill_d  = 1'b0;
                        state_d = c_FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imemRspValid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = c_FETCH;
                    end else begin
                        out_instr_d = imemRspData;
                        out_pc4_d   = w_pc_plus4;
                        pc_d        = w_pc_plus4;
                        out_valid_d = 1'b1;
                        state_d     = c_FULL;
                    end
                end
            end
            c_FULL: begin
                if (redirectValid || outReady) begin
                    out_valid_d = 1'b0;
                    state_d     = c_FETCH;
                end
            end
            default: begin
                state_d = c_FETCH;
            end
        endcase
    end

    // Output logic
    always_comb begin
        imemReq        = (state_q == c_FETCH) && !reset;
        imemAddr       = pc_q;
        outValid       = out_valid_q;
        outInstruction = out_instr_q;
        outPC4         = out_pc4_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A transaction
//               level model (outstanding request, squashed flag, held output
//               slot) predicts every output each cycle; directed scenarios add
//               literal expectations, then randomized traffic runs against a
//               variable-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic        outValid;
    logic [31:0] outInstruction;
    logic [31:0] outPC4;
    logic        outReady;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirectValid  (redirectValid),
        .redirectPC     (redirectPC),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemRspValid   (imemRspValid),
        .imemRspData    (imemRspData),
        .outValid       (outValid),
        .outInstruction (outInstruction),
        .outPC4         (outPC4),
        .outReady       (outReady)
    );

    int n_err = 0;
    int n_chk = 0;

    // Transaction-level model
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_pending;   // a request has been accepted, no response yet
    bit          m_stale;     // that outstanding request was squashed
    bit          m_held;      // an instruction is waiting for decode
    bit          m_init = 1'b0;

    // Memory model: countdown to the response of the accepted request
    int          mem_cnt = -1;
    logic [31:0] mem_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare against the model at the negedge, then advance the model with
    // the inputs applied in this cycle, then move past the next rising edge.
    task automatic cycle();
        bit acc;
        bit rsp;
        @(negedge clk);
        if (m_init) begin
            chk("imemReq",        {31'b0, imemReq},  {31'b0, (!reset && !m_pending && !m_held)});
            chk("imemAddr",       imemAddr,          m_pc);
            chk("outValid",       {31'b0, outValid}, {31'b0, m_held});
            chk("outInstruction", outInstruction,    m_instr);
            chk("outPC4",         outPC4,            m_pc4);
        end
        acc = !reset && !m_pending && !m_held && imemReady;
        rsp = m_pending && imemRspValid;
        if (reset) begin
            m_pc      = RESET_PC;
            m_pending = 1'b0;
            m_stale   = 1'b0;
            m_held    = 1'b0;
            m_instr   = 32'h0;
            m_pc4     = 32'h0;
            m_init    = 1'b1;
            mem_cnt   = -1;
        end else begin
            if (redirectValid) begin
                m_pc   = {redirectPC[31:2], 2'b00};
                m_held = 1'b0;
                if (acc) begin
                    m_pending = 1'b1;
                    m_stale   = 1'b1;
                end else if (rsp) begin
                    m_pending = 1'b0;
                    m_stale   = 1'b0;
                end else if (m_pending) begin
                    m_stale = 1'b1;
                end
            end else if (acc) begin
                m_pending = 1'b1;
            end else if (rsp) begin
                m_pending = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    m_held  = 1'b1;
                    m_instr = imemRspData;
                    m_pc4   = m_pc + 32'd4;
                    m_pc    = m_pc + 32'd4;
                end
            end else if (m_held && outReady) begin
                m_held = 1'b0;
            end
            if (acc) begin
                mem_cnt  = $urandom_range(2, 0);
                mem_data = $urandom;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset         = 1'b0;
        redirectValid = 1'b0;
        redirectPC    = 32'h0;
        imemReady     = 1'b0;
        imemRspValid  = 1'b0;
        imemRspData   = 32'h0;
        outReady      = 1'b0;
    endtask

    task automatic drive_rand();
        reset         = ($urandom_range(199, 0) == 0);
        redirectValid = ($urandom_range(7, 0) == 0);
        if ($urandom_range(3, 0) == 0)
            redirectPC = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
        else
            redirectPC = $urandom;
        imemReady = 1'($urandom_range(1, 0));
        outReady  = 1'($urandom_range(1, 0));
        if (mem_cnt == 0) begin
            imemRspValid = 1'b1;
            imemRspData  = mem_data;
            mem_cnt      = -1;
        end else begin
            if (mem_cnt > 0) mem_cnt--;
            // Stray strobes only while nothing is outstanding; they must be ignored.
            imemRspValid = (mem_cnt < 0) && ($urandom_range(15, 0) == 0);
            imemRspData  = $urandom;
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        cycle();
        cycle();
        // Reset state
        #1;
        chk("rst imemReq",  {31'b0, imemReq},  32'h0);
        chk("rst imemAddr", imemAddr,          RESET_PC);
        chk("rst outValid", {31'b0, outValid}, 32'h0);
        chk("rst outPC4",   outPC4,            32'h0);

        // 1: first fetch, one-cycle response
        reset = 1'b0; imemReady = 1'b1;
        #1;
        chk("t1 imemAddr", imemAddr,         32'h0);
        chk("t1 imemReq",  {31'b0, imemReq}, 32'h1);
        cycle();
        imemReady = 1'b0; imemRspValid = 1'b1; imemRspData = 32'h0800_0010;
        cycle();
        imemRspValid = 1'b0;
        #1;
        chk("t1 outValid",       {31'b0, outValid}, 32'h1);
        chk("t1 outInstruction", outInstruction,    32'h0800_0010);
        chk("t1 outPC4",         outPC4,            32'h4);
        outReady = 1'b1;
        cycle();
        outReady = 1'b0;
        #1;
        chk("t1 next imemAddr", imemAddr,          32'h4);
        chk("t1 outValid drop", {31'b0, outValid}, 32'h0);

        // 2: decode stall
        imemReady = 1'b1;
        cycle();
        imemReady = 1'b0; imemRspValid = 1'b1; imemRspData = 32'h1234_5678;
        cycle();
        imemRspValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2 outValid", {31'b0, outValid}, 32'h1);
            chk("t2 instr",    outInstruction,    32'h1234_5678);
            chk("t2 outPC4",   outPC4,            32'h8);
            chk("t2 imemReq",  {31'b0, imemReq},  32'h0);
            cycle();
        end

        // 3: redirect while holding an instruction
        redirectValid = 1'b1; redirectPC = 32'h0000_0041;
        cycle();
        redirectValid = 1'b0;
        #1;
        chk("t3 outValid", {31'b0, outValid}, 32'h0);
        chk("t3 imemAddr", imemAddr,          32'h0000_0040);
        chk("t3 imemReq",  {31'b0, imemReq},  32'h1);

        // 4: redirect while waiting, response two cycles later
        imemReady = 1'b1;
        cycle();
        imemReady = 1'b0; redirectValid = 1'b1; redirectPC = 32'h100;
        cycle();
        redirectValid = 1'b0;
        cycle();
        imemRspValid = 1'b1; imemRspData = 32'hDEAD_BEEF;
        cycle();
        imemRspValid = 1'b0;
        #1;
        chk("t4 outValid", {31'b0, outValid}, 32'h0);
        chk("t4 imemAddr", imemAddr,          32'h100);
        chk("t4 imemReq",  {31'b0, imemReq},  32'h1);
        cycle();
        chk("t4 still no outValid", {31'b0, outValid}, 32'h0);

        // 5: redirect coincident with the response
        imemReady = 1'b1;
        cycle();
        imemReady = 1'b0; redirectValid = 1'b1; redirectPC = 32'h200;
        imemRspValid = 1'b1; imemRspData = 32'hCAFE_F00D;
        cycle();
        redirectValid = 1'b0; imemRspValid = 1'b0;
        #1;
        chk("t5 outValid", {31'b0, outValid}, 32'h0);
        chk("t5 imemAddr", imemAddr,          32'h200);
        chk("t5 imemReq",  {31'b0, imemReq},  32'h1);

        // 6: PC wrap, then reset in WAIT
        redirectValid = 1'b1; redirectPC = 32'hFFFF_FFFC;
        cycle();
        redirectValid = 1'b0; imemReady = 1'b1;
        #1;
        chk("t6 imemAddr top", imemAddr, 32'hFFFF_FFFC);
        cycle();
        imemReady = 1'b0; imemRspValid = 1'b1; imemRspData = 32'h0000_0001;
        cycle();
        imemRspValid = 1'b0;
        #1;
        chk("t6 outValid", {31'b0, outValid}, 32'h1);
        chk("t6 outPC4",   outPC4,            32'h0);
        outReady = 1'b1;
        cycle();
        outReady = 1'b0;
        #1;
        chk("t6 wrap imemAddr", imemAddr, 32'h0);
        imemReady = 1'b1;
        cycle();
        imemReady = 1'b0; reset = 1'b1;
        cycle();
        #1;
        chk("t6 rst outValid", {31'b0, outValid}, 32'h0);
        chk("t6 rst imemAddr", imemAddr,          RESET_PC);
        chk("t6 rst imemReq",  {31'b0, imemReq},  32'h0);
        reset = 1'b0;
        #1;
        chk("t6 post-rst imemReq", {31'b0, imemReq}, 32'h1);

        // Randomized traffic against the model
        mem_cnt = -1;
        for (int c = 0; c < 4000; c++) begin
            drive_rand();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
